// File: rtl/clock_pkg.sv
// Shared definitions for the digital clock: alarm FSM state encoding and time field widths.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package clock_pkg;

    // Alarm sequencer states; the encoding is visible on the alarm_state port.
    typedef enum logic [1:0] {
        ST_DISARMED = 2'b00,
        ST_ARMED    = 2'b01,
        ST_RINGING  = 2'b10,
        ST_SNOOZED  = 2'b11
    } alarm_state_t;

    localparam int HH_W = 5;
    localparam int MM_W = 6;
    localparam int SS_W = 6;

    // True when the running time sits exactly on the first second of the alarm minute.
    function automatic logic alarm_time_hit(
        input logic [HH_W-1:0] cur_hh,
        input logic [MM_W-1:0] cur_mm,
        input logic [SS_W-1:0] cur_ss,
        input logic [HH_W-1:0] al_hh,
        input logic [MM_W-1:0] al_mm
    );
        return (cur_hh == al_hh) && (cur_mm == al_mm) && (cur_ss == '0);
    endfunction

endpackage

// File: rtl/sec_countdown.sv
// Loadable seconds down-counter; expire flags the tick that consumes the last second.
// Latency: count updates one cycle after load/tick; expire is combinational from tick and count.
// Backpressure: none; load has priority over tick, and the counter holds at zero instead of wrapping.
//
// Ports:
//   clock, reset     - system clock, synchronous active-high reset (count -> 0)
//   load, load_val   - load count with load_val
//   tick             - one-second strobe, already qualified by the owner
//   count            - seconds remaining
//   expire           - tick while count == 1
module sec_countdown #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic [W-1:0] count,
    output logic         expire
);

    assign expire = tick && (count == W'(1));

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && (count != '0)) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/alarm_scheduler.sv
// Alarm sequencer: arms on al_en, rings at the alarm minute, handles stop/snooze/timeout/disable.
// Latency: every output is registered; a trigger tick or button pulse in cycle N shows in cycle N+1.
// Backpressure: none; press pulses are consumed in the cycle they arrive, and a pulse beats a coincident tick.
//
// Ports:
//   clock, reset                 - system clock, synchronous active-high reset
//   tick_1s                      - one pulse per second; cur_* valid in that cycle
//   cur_hh/cur_mm/cur_ss         - running time
//   al_hh/al_mm, al_en           - stored alarm time and enable level
//   setting_busy                 - a time is being edited; suppresses the trigger
//   stop_short/stop_long         - stop button press pulses
//   snooze_req                   - snooze button press pulse
//   buzz, ring_led               - buzzer drive and blinking LED
//   alarm_state, snooze_cnt      - FSM state and snoozes used in the current event
module alarm_scheduler
    import clock_pkg::*;
#(
    parameter int SNOOZE_MIN     = 5,
    parameter int RING_TIMEOUT_S = 60,
    parameter int MAX_SNOOZE     = 3
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            tick_1s,
    input  logic [HH_W-1:0] cur_hh,
    input  logic [MM_W-1:0] cur_mm,
    input  logic [SS_W-1:0] cur_ss,
    input  logic [HH_W-1:0] al_hh,
    input  logic [MM_W-1:0] al_mm,
    input  logic            al_en,
    input  logic            setting_busy,
    input  logic            stop_short,
    input  logic            stop_long,
    input  logic            snooze_req,
    output logic            buzz,
    output logic            ring_led,
    output logic [1:0]      alarm_state,
    output logic [1:0]      snooze_cnt
);

    localparam int SNOOZE_S = SNOOZE_MIN * 60;
    localparam int RING_W   = $clog2(RING_TIMEOUT_S + 1);
    localparam int SNZ_W    = $clog2(SNOOZE_S + 1);

    localparam logic [RING_W-1:0] RING_LOAD = RING_W'(RING_TIMEOUT_S);
    localparam logic [SNZ_W-1:0]  SNZ_LOAD  = SNZ_W'(SNOOZE_S);
    localparam logic [1:0]        SNZ_MAX   = 2'(MAX_SNOOZE);

    alarm_state_t state;

    logic              stop_any;
    logic              trigger;
    logic              snooze_ok;
    logic              ring_tick;
    logic              snz_tick;
    logic              ring_load;
    logic              ring_expire;
    logic              snz_expire;
    logic [RING_W-1:0] ring_count;
    logic [SNZ_W-1:0]  snz_count;

    assign alarm_state = state;

    // Event decode. Each timer only sees ticks that no higher-priority event
    // claimed, so a pulse coincident with tick_1s leaves the timer untouched.
    always_comb begin
        stop_any  = stop_short || stop_long;
        trigger   = 1'b0;
        snooze_ok = 1'b0;
        ring_tick = 1'b0;
        snz_tick  = 1'b0;
        unique case (state)
            ST_ARMED: begin
                trigger = al_en && tick_1s && !setting_busy &&
                          alarm_time_hit(cur_hh, cur_mm, cur_ss, al_hh, al_mm);
            end
            ST_RINGING: begin
                // An over-limit snooze press is treated as no press at all.
                snooze_ok = al_en && !stop_any && snooze_req && (snooze_cnt < SNZ_MAX);
                ring_tick = al_en && !stop_any && !snooze_ok && tick_1s;
            end
            ST_SNOOZED: begin
                snz_tick = al_en && !stop_any && tick_1s;
            end
            default: begin
            end
        endcase
    end

    // The ring timer is reloaded both on the first trigger and on every snooze expiry.
    assign ring_load = trigger || snz_expire;

    sec_countdown #(.W(RING_W)) u_ring_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (ring_load),
        .load_val (RING_LOAD),
        .tick     (ring_tick),
        .count    (ring_count),
        .expire   (ring_expire)
    );

    sec_countdown #(.W(SNZ_W)) u_snooze_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (snooze_ok),
        .load_val (SNZ_LOAD),
        .tick     (snz_tick),
        .count    (snz_count),
        .expire   (snz_expire)
    );

    // State and registered outputs. buzz/ring_led are written alongside every
    // state change so they always agree with the state they belong to.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_DISARMED;
            buzz       <= 1'b0;
            ring_led   <= 1'b0;
            snooze_cnt <= 2'd0;
        end else begin
            unique case (state)
                ST_DISARMED: begin
                    buzz     <= 1'b0;
                    ring_led <= 1'b0;
                    if (al_en) begin
                        state <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (!al_en) begin
                        state <= ST_DISARMED;
                    end else if (trigger) begin
                        state      <= ST_RINGING;
                        buzz       <= 1'b1;
                        ring_led   <= 1'b1;
                        snooze_cnt <= 2'd0;
                    end
                end
                ST_RINGING: begin
                    if (!al_en) begin
                        state    <= ST_DISARMED;
                        buzz     <= 1'b0;
                        ring_led <= 1'b0;
                    end else if (stop_any) begin
                        state    <= ST_ARMED;
                        buzz     <= 1'b0;
                        ring_led <= 1'b0;
                    end else if (snooze_ok) begin
                        state      <= ST_SNOOZED;
                        buzz       <= 1'b0;
                        ring_led   <= 1'b0;
                        snooze_cnt <= snooze_cnt + 2'd1;
                    end else if (ring_expire) begin
                        state    <= ST_ARMED;
                        buzz     <= 1'b0;
                        ring_led <= 1'b0;
                    end else if (tick_1s) begin
                        ring_led <= ~ring_led;
                    end
                end
                ST_SNOOZED: begin
                    if (!al_en) begin
                        state <= ST_DISARMED;
                    end else if (stop_any) begin
                        state <= ST_ARMED;
                    end else if (snz_expire) begin
                        state    <= ST_RINGING;
                        buzz     <= 1'b1;
                        ring_led <= 1'b1;
                    end
                end
                default: begin
                    state    <= ST_DISARMED;
                    buzz     <= 1'b0;
                    ring_led <= 1'b0;
                end
            endcase
        end
    end

endmodule
